// File: rtl/id_pkg.sv
// Shared decode constants for the ARM-subset decode stage: ALU encodings,
// op-class and cmd fields, immediate-source selector and special register indices.
package id_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned FLAG_W  = 2;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_ORR = 4'b0011;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // flag_write[1] updates N/Z, flag_write[0] updates C/V
  localparam logic [FLAG_W-1:0] FLAGS_NONE = 2'b00;
  localparam logic [FLAG_W-1:0] FLAGS_NZ   = 2'b10;
  localparam logic [FLAG_W-1:0] FLAGS_ALL  = 2'b11;

  typedef enum logic [1:0] {
    IMM_DP8   = 2'b00,
    IMM_MEM12 = 2'b01,
    IMM_BR24  = 2'b10
  } imm_src_e;

  localparam int unsigned REG_LR = 14;

  // The PC is always the highest-numbered architectural register
  function automatic int unsigned pc_index(input int unsigned nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational field decode and immediate extension for the supported ARM subset.
module id_decoder
  import id_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 4
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [RA_W-1:0]    rd_c,
  output logic [RA_W-1:0]    rn_c,
  output logic [RA_W-1:0]    rm_c,
  output logic [RA_W-1:0]    ra_b_c,
  output logic               use_a_c,
  output logic               use_b_c,
  output logic [DATA_W-1:0]  ext_imm_c,
  output logic [ALU_W-1:0]   alu_ctrl_c,
  output logic [FLAG_W-1:0]  flag_write_c,
  output logic               reg_write_c,
  output logic               mem_write_c,
  output logic               mem_to_reg_c,
  output logic               alu_src_c,
  output logic               branch_c,
  output logic               link_c
);

  logic [1:0] op;
  logic [3:0] cmd;
  logic       i_bit;
  logic       s_bit;
  imm_src_e   imm_src;
  logic       unused_cond_c;

  assign op            = instr[27:26];
  assign cmd           = instr[24:21];
  assign i_bit         = instr[25];
  assign s_bit         = instr[20];
  assign unused_cond_c = ^instr[31:28];

  // Control decode; the second read port carries Rd for stores, Rm otherwise
  always_comb begin
    rd_c         = RA_W'(instr[15:12]);
    rn_c         = RA_W'(instr[19:16]);
    rm_c         = RA_W'(instr[3:0]);
    ra_b_c       = RA_W'(instr[3:0]);
    use_a_c      = 1'b0;
    use_b_c      = 1'b0;
    alu_ctrl_c   = ALU_ADD;
    flag_write_c = FLAGS_NONE;
    reg_write_c  = 1'b0;
    mem_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_c    = 1'b0;
    branch_c     = 1'b0;
    link_c       = 1'b0;
    imm_src      = IMM_DP8;

    case (op)
      OP_DP: begin
        alu_src_c = i_bit;
        use_a_c   = 1'b1;
        use_b_c   = ~i_bit;
        imm_src   = IMM_DP8;
        case (cmd)
          CMD_ADD: begin
            alu_ctrl_c   = ALU_ADD;
            reg_write_c  = 1'b1;
            flag_write_c = s_bit ? FLAGS_ALL : FLAGS_NONE;
          end
          CMD_SUB: begin
            alu_ctrl_c   = ALU_SUB;
            reg_write_c  = 1'b1;
            flag_write_c = s_bit ? FLAGS_ALL : FLAGS_NONE;
          end
          CMD_AND: begin
            alu_ctrl_c   = ALU_AND;
            reg_write_c  = 1'b1;
            flag_write_c = s_bit ? FLAGS_NZ : FLAGS_NONE;
          end
          CMD_ORR: begin
            alu_ctrl_c   = ALU_ORR;
            reg_write_c  = 1'b1;
            flag_write_c = s_bit ? FLAGS_NZ : FLAGS_NONE;
          end
          CMD_CMP: begin
            alu_ctrl_c   = ALU_SUB;
            flag_write_c = FLAGS_ALL;
          end
          default: ;
        endcase
      end
      OP_MEM: begin
        alu_src_c = 1'b1;
        use_a_c   = 1'b1;
        imm_src   = IMM_MEM12;
        if (instr[20]) begin
          reg_write_c  = 1'b1;
          mem_to_reg_c = 1'b1;
        end else begin
          mem_write_c = 1'b1;
          use_b_c     = 1'b1;
          ra_b_c      = RA_W'(instr[15:12]);
        end
      end
      OP_BR: begin
        branch_c  = 1'b1;
        alu_src_c = 1'b1;
        imm_src   = IMM_BR24;
        if (instr[24]) begin
          link_c      = 1'b1;
          reg_write_c = 1'b1;
          rd_c        = RA_W'(REG_LR);
        end
      end
      default: ;
    endcase
  end

  // Immediate extension
  always_comb begin
    ext_imm_c = '0;
    case (imm_src)
      IMM_DP8:   ext_imm_c = DATA_W'(instr[7:0]);
      IMM_MEM12: ext_imm_c = DATA_W'(instr[11:0]);
      IMM_BR24:  ext_imm_c = DATA_W'($signed({instr[23:0], 2'b00}));
      default:   ext_imm_c = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register with handshake/flush, register file with PC+8 reads,
// and a per-register pending-write scoreboard. IDECODE_BYPASS_EN enables writeback forwarding.
module id_stage
  import id_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned NREGS  = 16,
  parameter  int unsigned PEND_W = 2,
  localparam int unsigned RA_W   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_f_valid,
  output logic               instr_f_ready,
  input  logic [INSTR_W-1:0] instr_f,
  input  logic [DATA_W-1:0]  pc_plus8_f,
  input  logic               flush,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [RA_W-1:0]    rd_d,
  output logic [RA_W-1:0]    rn_d,
  output logic [RA_W-1:0]    rm_d,
  output logic [DATA_W-1:0]  src_a_d,
  output logic [DATA_W-1:0]  src_b_d,
  output logic [DATA_W-1:0]  ext_imm_d,
  output logic [ALU_W-1:0]   alu_ctrl_d,
  output logic [FLAG_W-1:0]  flag_write_d,
  output logic               reg_write_d,
  output logic               mem_write_d,
  output logic               mem_to_reg_d,
  output logic               alu_src_d,
  output logic               branch_d,
  output logic               link_d,
  input  logic               reg_write_w,
  input  logic [RA_W-1:0]    rd_w,
  input  logic [DATA_W-1:0]  result_w,
  input  logic               cancel_valid,
  input  logic [RA_W-1:0]    cancel_rd
);

  localparam int unsigned    SUM_W  = PEND_W + 2;
  localparam logic [RA_W-1:0] PC_IDX = RA_W'(pc_index(NREGS));

  logic                id_valid;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   pc8_q;

  logic [DATA_W-1:0]   rf [NREGS];
  logic [PEND_W-1:0]   pend [NREGS];
  logic [PEND_W-1:0]   pend_nxt [NREGS];
  logic [SUM_W-1:0]    pend_sum;

  logic [RA_W-1:0]     ra_b;
  logic                use_a;
  logic                use_b;
  logic                wb_live;
  logic                busy_a;
  logic                busy_b;
  logic                sat_rd;
  logic                hazard;
  logic                dec_fire;

  id_decoder #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W)
  ) u_decoder (
    .instr        (instr_q),
    .rd_c         (rd_d),
    .rn_c         (rn_d),
    .rm_c         (rm_d),
    .ra_b_c       (ra_b),
    .use_a_c      (use_a),
    .use_b_c      (use_b),
    .ext_imm_c    (ext_imm_d),
    .alu_ctrl_c   (alu_ctrl_d),
    .flag_write_c (flag_write_d),
    .reg_write_c  (reg_write_d),
    .mem_write_c  (mem_write_d),
    .mem_to_reg_c (mem_to_reg_d),
    .alu_src_c    (alu_src_d),
    .branch_c     (branch_d),
    .link_c       (link_d)
  );

  assign wb_live       = reg_write_w && (rd_w != PC_IDX);
  assign dec_valid     = id_valid && !hazard && !flush;
  assign dec_fire      = dec_valid && dec_ready;
  assign instr_f_ready = !id_valid || dec_fire;

  // IF/ID register: flush wins over capture, capture wins over drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid <= 1'b0;
      instr_q  <= '0;
      pc8_q    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (instr_f_valid && instr_f_ready) begin
      id_valid <= 1'b1;
      instr_q  <= instr_f;
      pc8_q    <= pc_plus8_f;
    end else if (dec_fire) begin
      id_valid <= 1'b0;
    end
  end

  // Register file; the PC slot is never written, reads of it return pc8_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NREGS); r++) rf[r] <= '0;
    end else if (wb_live) begin
      rf[rd_w] <= result_w;
    end
  end

  always_comb begin
    src_a_d = rf[rn_d];
    src_b_d = rf[ra_b];
    if (rn_d == PC_IDX) src_a_d = pc8_q;
`ifdef IDECODE_BYPASS_EN
    else if (wb_live && (rd_w == rn_d)) src_a_d = result_w;
`endif
    if (ra_b == PC_IDX) src_b_d = pc8_q;
`ifdef IDECODE_BYPASS_EN
    else if (wb_live && (rd_w == ra_b)) src_b_d = result_w;
`endif
  end

  // RAW and scoreboard-capacity hazard detection
  always_comb begin
    busy_a = use_a && (rn_d != PC_IDX) && (pend[rn_d] != '0);
    busy_b = use_b && (ra_b != PC_IDX) && (pend[ra_b] != '0);
`ifdef IDECODE_BYPASS_EN
    if (busy_a && (pend[rn_d] == PEND_W'(1)) && reg_write_w && (rd_w == rn_d)) busy_a = 1'b0;
    if (busy_b && (pend[ra_b] == PEND_W'(1)) && reg_write_w && (rd_w == ra_b)) busy_b = 1'b0;
`endif
    sat_rd = reg_write_d && (pend[rd_d] == '1);
    hazard = busy_a || busy_b || sat_rd;
  end

  // Net per-register change from issue, retire and cancel; clamped at both ends
  always_comb begin
    pend_sum = '0;
    for (int r = 0; r < int'(NREGS); r++) begin
      pend_sum = SUM_W'(pend[r])
               + SUM_W'(dec_fire && reg_write_d && (rd_d == RA_W'(r)))
               - SUM_W'(reg_write_w && (rd_w == RA_W'(r)))
               - SUM_W'(cancel_valid && (cancel_rd == RA_W'(r)));
      if (pend_sum[SUM_W-1])      pend_nxt[r] = '0;
      else if (pend_sum[PEND_W])  pend_nxt[r] = '1;
      else                        pend_nxt[r] = pend_sum[PEND_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NREGS); r++) pend[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NREGS); r++) pend[r] <= pend_nxt[r];
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage; expectations follow IDECODE_BYPASS_EN when defined.
module tb_id_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RA_W   = 4;

  logic              clk;
  logic              reset;
  logic              instr_f_valid;
  logic              instr_f_ready;
  logic [31:0]       instr_f;
  logic [DATA_W-1:0] pc_plus8_f;
  logic              flush;
  logic              dec_valid;
  logic              dec_ready;
  logic [RA_W-1:0]   rd_d, rn_d, rm_d;
  logic [DATA_W-1:0] src_a_d, src_b_d, ext_imm_d;
  logic [3:0]        alu_ctrl_d;
  logic [1:0]        flag_write_d;
  logic              reg_write_d, mem_write_d, mem_to_reg_d, alu_src_d, branch_d, link_d;
  logic              reg_write_w;
  logic [RA_W-1:0]   rd_w;
  logic [DATA_W-1:0] result_w;
  logic              cancel_valid;
  logic [RA_W-1:0]   cancel_rd;

  int n_tests;
  int n_fail;

  id_stage dut (
    .clk           (clk),
    .reset         (reset),
    .instr_f_valid (instr_f_valid),
    .instr_f_ready (instr_f_ready),
    .instr_f       (instr_f),
    .pc_plus8_f    (pc_plus8_f),
    .flush         (flush),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .rd_d          (rd_d),
    .rn_d          (rn_d),
    .rm_d          (rm_d),
    .src_a_d       (src_a_d),
    .src_b_d       (src_b_d),
    .ext_imm_d     (ext_imm_d),
    .alu_ctrl_d    (alu_ctrl_d),
    .flag_write_d  (flag_write_d),
    .reg_write_d   (reg_write_d),
    .mem_write_d   (mem_write_d),
    .mem_to_reg_d  (mem_to_reg_d),
    .alu_src_d     (alu_src_d),
    .branch_d      (branch_d),
    .link_d        (link_d),
    .reg_write_w   (reg_write_w),
    .rd_w          (rd_w),
    .result_w      (result_w),
    .cancel_valid  (cancel_valid),
    .cancel_rd     (cancel_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc8);
    instr_f       = ins;
    pc_plus8_f    = pc8;
    instr_f_valid = 1'b1;
    step();
    instr_f_valid = 1'b0;
    #1;
  endtask

  task automatic writeback(input logic [3:0] r, input logic [31:0] v);
    reg_write_w = 1'b1;
    rd_w        = r;
    result_w    = v;
    step();
    reg_write_w = 1'b0;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    instr_f_valid = 1'b0;
    instr_f = '0;
    pc_plus8_f = '0;
    flush = 1'b0;
    dec_ready = 1'b1;
    reg_write_w = 1'b0;
    rd_w = '0;
    result_w = '0;
    cancel_valid = 1'b0;
    cancel_rd = '0;

    // Reset state: empty ID register holding a zero word (AND R0,R0,R0)
    step();
    step();
    check_eq("rst_dec_valid", 32'(dec_valid), 32'd0);
    check_eq("rst_f_ready", 32'(instr_f_ready), 32'd1);
    check_eq("rst_alu_ctrl", 32'(alu_ctrl_d), 32'h2);
    check_eq("rst_ext_imm", ext_imm_d, 32'h0);
    reset = 1'b0;
    #1;

    writeback(4'd2, 32'd7);

    // ADD R1,R2,#5
    issue(32'hE2821005, 32'h108);
    check_eq("add_dec_valid", 32'(dec_valid), 32'd1);
    check_eq("add_alu_ctrl", 32'(alu_ctrl_d), 32'h0);
    check_eq("add_ext_imm", ext_imm_d, 32'd5);
    check_eq("add_src_a", src_a_d, 32'd7);
    check_eq("add_reg_write", 32'(reg_write_d), 32'd1);
    check_eq("add_rd", 32'(rd_d), 32'd1);
    check_eq("add_alu_src", 32'(alu_src_d), 32'd1);
    check_eq("add_flags", 32'(flag_write_d), 32'd0);

    // SUB R3,R1,#1 back-to-back: RAW on R1
    issue(32'hE2413001, 32'h10C);
    check_eq("sub_stall0", 32'(dec_valid), 32'd0);
    step();
    check_eq("sub_stall1", 32'(dec_valid), 32'd0);
    reg_write_w = 1'b1;
    rd_w = 4'd1;
    result_w = 32'h55;
    #1;
`ifdef IDECODE_BYPASS_EN
    check_eq("sub_byp_valid", 32'(dec_valid), 32'd1);
    check_eq("sub_byp_src_a", src_a_d, 32'h55);
    check_eq("sub_alu_ctrl", 32'(alu_ctrl_d), 32'h1);
    step();
    reg_write_w = 1'b0;
    #1;
    check_eq("sub_byp_drained", 32'(dec_valid), 32'd0);
`else
    check_eq("sub_nobyp_stall", 32'(dec_valid), 32'd0);
    step();
    reg_write_w = 1'b0;
    #1;
    check_eq("sub_nobyp_valid", 32'(dec_valid), 32'd1);
    check_eq("sub_nobyp_src_a", src_a_d, 32'h55);
    check_eq("sub_alu_ctrl", 32'(alu_ctrl_d), 32'h1);
    step();
`endif
    writeback(4'd3, 32'h33);

    // STR R2,[R1,#8] held by backpressure with BL waiting at fetch
    dec_ready = 1'b0;
    issue(32'hE5812008, 32'h300);
    instr_f = 32'hEBFFFFFE;
    pc_plus8_f = 32'h400;
    instr_f_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("str_hold_valid", 32'(dec_valid), 32'd1);
      check_eq("str_hold_ready", 32'(instr_f_ready), 32'd0);
      check_eq("str_hold_src_b", src_b_d, 32'd7);
      check_eq("str_hold_src_a", src_a_d, 32'h55);
      check_eq("str_hold_memw", 32'(mem_write_d), 32'd1);
      check_eq("str_hold_imm", ext_imm_d, 32'd8);
      check_eq("str_hold_regw", 32'(reg_write_d), 32'd0);
      step();
    end
    dec_ready = 1'b1;
    #1;
    check_eq("str_release_ready", 32'(instr_f_ready), 32'd1);
    step();

    // BL backwards, then flush the following instruction and cancel LR
    instr_f = 32'hE2826001;
    pc_plus8_f = 32'h408;
    #1;
    check_eq("bl_valid", 32'(dec_valid), 32'd1);
    check_eq("bl_branch", 32'(branch_d), 32'd1);
    check_eq("bl_link", 32'(link_d), 32'd1);
    check_eq("bl_rd", 32'(rd_d), 32'd14);
    check_eq("bl_regw", 32'(reg_write_d), 32'd1);
    check_eq("bl_imm", ext_imm_d, 32'hFFFFFFF8);
    step();
    instr_f_valid = 1'b0;
    flush = 1'b1;
    #1;
    check_eq("flush_dec_valid", 32'(dec_valid), 32'd0);
    check_eq("flush_f_ready", 32'(instr_f_ready), 32'd0);
    step();
    flush = 1'b0;
    cancel_valid = 1'b1;
    cancel_rd = 4'd14;
    #1;
    check_eq("flush_killed", 32'(dec_valid), 32'd0);
    step();
    cancel_valid = 1'b0;
    issue(32'hE28E5000, 32'h500);
    check_eq("lr_cancel_valid", 32'(dec_valid), 32'd1);
    check_eq("lr_cancel_src_a", src_a_d, 32'd0);

    // CMP R2,#7
    issue(32'hE3520007, 32'h504);
    check_eq("cmp_valid", 32'(dec_valid), 32'd1);
    check_eq("cmp_alu", 32'(alu_ctrl_d), 32'h1);
    check_eq("cmp_flags", 32'(flag_write_d), 32'h3);
    check_eq("cmp_regw", 32'(reg_write_d), 32'd0);
    check_eq("cmp_src_a", src_a_d, 32'd7);

    // ANDS R8,R2,R3 (register operand)
    issue(32'hE0128003, 32'h508);
    check_eq("ands_alu", 32'(alu_ctrl_d), 32'h2);
    check_eq("ands_flags", 32'(flag_write_d), 32'h2);
    check_eq("ands_alu_src", 32'(alu_src_d), 32'd0);
    check_eq("ands_src_b", src_b_d, 32'h33);
    check_eq("ands_rm", 32'(rm_d), 32'd3);

    // ADD R9,R15,#0 reads the captured PC+8
    issue(32'hE28F9000, 32'h1234);
    check_eq("pc_read_src_a", src_a_d, 32'h1234);

    // Four writes to R4: the fourth waits on a saturated counter
    instr_f = 32'hE2824001;
    pc_plus8_f = 32'h600;
    instr_f_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("r4_issue_valid", 32'(dec_valid), 32'd1);
    end
    step();
    instr_f_valid = 1'b0;
    #1;
    check_eq("r4_sat_stall0", 32'(dec_valid), 32'd0);
    step();
    check_eq("r4_sat_stall1", 32'(dec_valid), 32'd0);
    check_eq("r4_sat_f_ready", 32'(instr_f_ready), 32'd0);
    reg_write_w = 1'b1;
    rd_w = 4'd4;
    result_w = 32'h44;
    #1;
    check_eq("r4_sat_retire", 32'(dec_valid), 32'd0);
    step();
    reg_write_w = 1'b0;
    #1;
    check_eq("r4_sat_released", 32'(dec_valid), 32'd1);

    // ADD R7,R4,#0 stalls on R4; reset in the middle of the stall
    issue(32'hE2847000, 32'h700);
    check_eq("r7_stall", 32'(dec_valid), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("midrst_dec_valid", 32'(dec_valid), 32'd0);
    check_eq("midrst_f_ready", 32'(instr_f_ready), 32'd1);
    step();
    reset = 1'b0;
    #1;
    issue(32'hE2847000, 32'h700);
    check_eq("post_rst_valid", 32'(dec_valid), 32'd1);
    check_eq("post_rst_src_a", src_a_d, 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
